// File: rtl/sample_stream_serializer.sv
// sample_stream_serializer
// Buffers 64-bit words from the sampling writer stage in a register FIFO and
// streams each one to the 32-bit host interface as two valid/ready beats,
// low half first. Writes that arrive while the FIFO is full are dropped and
// recorded in a sticky overflow flag and a saturating 16-bit drop counter.
module sample_stream_serializer #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          write,
    input  logic [63:0]   data_in,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [31:0]   out_data,
    output logic          out_last,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic [15:0]   drop_count
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_LOW   = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;

    // Saturating increment for the drop counter: sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [1:0]    state;
    logic [63:0]   hold;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Full/empty are judged on the registered count, so a write in the same
    // cycle as a pop from a full FIFO is still dropped.
    always_comb begin
        full  = (count == FULL_CNT);
        empty = (count == '0);
        push  = write && !full;
        pop   = !empty && ((state == S_EMPTY) || ((state == S_HIGH) && out_ready));
    end

    // FIFO storage: data only, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Holding register for the word currently being serialized.
    always_ff @(posedge clk) begin
        if (pop) begin
            hold <= mem[rd_ptr];
        end
    end

    // Pointers, occupancy, serializer state and drop bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= S_EMPTY;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (write && full) begin
                overflow   <= 1'b1;
                drop_count <= sat_inc16(drop_count);
            end
            case (state)
                S_EMPTY: if (pop) state <= S_LOW;
                S_LOW:   if (out_ready) state <= S_HIGH;
                S_HIGH:  if (out_ready) state <= pop ? S_LOW : S_EMPTY;
                default: state <= S_EMPTY;
            endcase
        end
    end

    // Beat outputs decode directly from the registered state and hold word,
    // so they stay stable for as long as the host stalls.
    always_comb begin
        out_valid = (state != S_EMPTY);
        out_last  = (state == S_HIGH);
        level     = count;
        case (state)
            S_LOW:   out_data = hold[31:0];
            S_HIGH:  out_data = hold[63:32];
            default: out_data = '0;
        endcase
    end

endmodule

// File: tb/tb_sample_stream_serializer.sv
// Testbench for sample_stream_serializer: scenario tasks with inline checks
// against a queue-based beat scoreboard.
module tb_sample_stream_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        write;
    logic [63:0] data_in;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] drop_count;

    int checks = 0;
    int failures = 0;

    sample_stream_serializer #(.AW(4)) dut (
        .clk(clk), .reset(reset), .write(write), .data_in(data_in),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .level(level), .overflow(overflow),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs set after this apply to the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        write = 1'b0; data_in = '0; out_ready = 1'b0; reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%0b want=0", out_last); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h want=0", out_data); end
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d want=0", level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b want=0", overflow); end
        checks++; if (drop_count !== 16'h0) begin failures++; $display("FAIL reset_drops got=%0d want=0", drop_count); end
    endtask

    task automatic test_single_word();
        do_reset();
        write = 1'b1; data_in = 64'h1111_2222_3333_4444; out_ready = 1'b1;
        tick();
        write = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_c1_valid got=%0b want=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h3333_4444 || out_last !== 1'b0) begin
            failures++; $display("FAIL single_c2 got v=%0b d=%h l=%0b want v=1 d=33334444 l=0", out_valid, out_data, out_last); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h1111_2222 || out_last !== 1'b1) begin
            failures++; $display("FAIL single_c3 got v=%0b d=%h l=%0b want v=1 d=11112222 l=1", out_valid, out_data, out_last); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_c4_valid got=%0b want=0", out_valid); end
    endtask

    task automatic test_back_pressure();
        logic [63:0] w [3];
        logic [31:0] exp_d;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w[i] = rand64();
            write = 1'b1; data_in = w[i];
            tick();
        end
        write = 1'b0;
        for (int c = 0; c < 10; c++) begin
            checks++; if (level !== 5'd2 || out_valid !== 1'b1 || out_data !== w[0][31:0]) begin
                failures++; $display("FAIL stall_c%0d got lvl=%0d v=%0b d=%h want lvl=2 v=1 d=%h", c, level, out_valid, out_data, w[0][31:0]); end
            tick();
        end
        out_ready = 1'b1;
        for (int b = 0; b < 6; b++) begin
            exp_d = (b % 2 == 0) ? w[b/2][31:0] : w[b/2][63:32];
            checks++; if (out_valid !== 1'b1 || out_data !== exp_d || out_last !== 1'(b % 2)) begin
                failures++; $display("FAIL bp_beat%0d got v=%0b d=%h l=%0b want v=1 d=%h l=%0d", b, out_valid, out_data, out_last, exp_d, b % 2); end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_after_valid got=%0b want=0", out_valid); end
    endtask

    task automatic test_overflow_saturation();
        logic [63:0] w [18];
        logic [31:0] exp_d;
        int got;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            w[i] = rand64();
            write = 1'b1; data_in = w[i];
            tick();
        end
        write = 1'b0;
        checks++; if (level !== 5'd16) begin failures++; $display("FAIL ovf_level got=%0d want=16", level); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b want=1", overflow); end
        checks++; if (drop_count !== 16'd1) begin failures++; $display("FAIL ovf_drops got=%0d want=1", drop_count); end
        // 70000 more drops push the counter far past its ceiling.
        write = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            data_in = rand64();
            tick();
        end
        write = 1'b0;
        checks++; if (drop_count !== 16'hFFFF) begin failures++; $display("FAIL sat_drops got=%h want=ffff", drop_count); end
        checks++; if (level !== 5'd16) begin failures++; $display("FAIL sat_level got=%0d want=16", level); end
        // Drain: words 0..16 survive, word 17 and all later writes were dropped.
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 100 && got < 34; c++) begin
            if (out_valid) begin
                exp_d = (got % 2 == 0) ? w[got/2][31:0] : w[got/2][63:32];
                checks++; if (out_data !== exp_d || out_last !== 1'(got % 2)) begin
                    failures++; $display("FAIL ovf_drain_beat%0d got d=%h l=%0b want d=%h l=%0d", got, out_data, out_last, exp_d, got % 2); end
                got++;
            end
            tick();
        end
        checks++; if (got != 34) begin failures++; $display("FAIL ovf_drain_count got=%0d want=34", got); end
        checks++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            failures++; $display("FAIL ovf_end got v=%0b ovf=%0b want v=0 ovf=1", out_valid, overflow); end
    endtask

    task automatic test_wrap_order();
        logic [32:0] exp_q [$];
        logic [32:0] e;
        logic [63:0] wd;
        logic        prev_stall;
        logic [31:0] prev_d;
        logic        prev_l;
        int sent, got;
        do_reset();
        sent = 0; got = 0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
        for (int c = 0; c < 600 && got < 80; c++) begin
            write = (c % 2 == 0) && (sent < 40);
            if (write) begin
                wd = 64'h1000_0000_2000_0000 + 64'(sent) * 64'h0000_0001_0000_0001;
                data_in = wd;
                exp_q.push_back({1'b0, wd[31:0]});
                exp_q.push_back({1'b1, wd[63:32]});
                sent++;
            end
            out_ready = (sent < 40) ? ($urandom_range(0, 7) != 0) : 1'b1;
            checks++; if (level > 5'd16) begin failures++; $display("FAIL wrap_level got=%0d want<=16", level); end
            if (prev_stall) begin
                checks++; if (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l) begin
                    failures++; $display("FAIL wrap_stable got v=%0b d=%h l=%0b want v=1 d=%h l=%0b", out_valid, out_data, out_last, prev_d, prev_l); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL wrap_extra_beat got d=%h want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e[31:0] || out_last !== e[32]) begin
                        failures++; $display("FAIL wrap_beat%0d got d=%h l=%0b want d=%h l=%0b", got, out_data, out_last, e[31:0], e[32]); end
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data; prev_l = out_last;
            tick();
        end
        write = 1'b0;
        checks++; if (got != 80) begin failures++; $display("FAIL wrap_count got=%0d want=80", got); end
        checks++; if (drop_count !== 16'd0 || overflow !== 1'b0) begin
            failures++; $display("FAIL wrap_drops got=%0d ovf=%0b want 0 0", drop_count, overflow); end
    endtask

    task automatic test_reset_mid_word();
        logic [63:0] w [6];
        logic [63:0] nw;
        int sent, beats;
        logic seen;
        do_reset();
        out_ready = 1'b1; sent = 0; beats = 0; seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            write = (c % 2 == 0) && (sent < 6);
            if (write) begin
                w[sent] = rand64(); data_in = w[sent]; sent++;
            end
            if (out_valid && out_ready) begin
                if (beats == 10) begin
                    checks++; if (out_data !== w[5][31:0] || out_last !== 1'b0) begin
                        failures++; $display("FAIL rmw_w5_low got d=%h l=%0b want d=%h l=0", out_data, out_last, w[5][31:0]); end
                    seen = 1'b1;
                end
                beats++;
            end
            tick();
        end
        checks++; if (!seen) begin failures++; $display("FAIL rmw_timeout got beats=%0d want 11", beats); end
        write = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0 || level !== 5'd0 || overflow !== 1'b0) begin
            failures++; $display("FAIL rmw_after_reset got v=%0b lvl=%0d ovf=%0b want 0 0 0", out_valid, level, overflow); end
        nw = rand64();
        write = 1'b1; data_in = nw;
        tick();
        write = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmw_new_c1 got v=%0b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== nw[31:0] || out_last !== 1'b0) begin
            failures++; $display("FAIL rmw_new_c2 got v=%0b d=%h l=%0b want v=1 d=%h l=0", out_valid, out_data, out_last, nw[31:0]); end
    endtask

    initial begin
        reset = 1'b1; write = 1'b0; data_in = '0; out_ready = 1'b0;
        test_reset();
        test_single_word();
        test_back_pressure();
        test_overflow_saturation();
        test_wrap_order();
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
